// File: rtl/accum_pkg.sv
// Shared constants for the accumulator ALU sequencer: widths, opcodes and FSM encoding.
package accum_pkg;

  localparam int ACC_WIDTH = 8;
  localparam int ACC_OPW   = 3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_PASS = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MUL  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/shift_add_mul8.sv
// Iterative unsigned shift-add multiplier; one partial product per clock after init.
module shift_add_mul8
  import accum_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] partial_s;

  // product already includes this cycle's partial, so the final value is usable on the last step
  always_comb begin
    if (mplier_q[0]) begin
      partial_s = mcand_q;
    end else begin
      partial_s = {(2*WIDTH){1'b0}};
    end
    product = prod_q + partial_s;
    last    = (count_q == CW'(WIDTH-1));
  end

  // next-state for the shift-add iteration
  always_comb begin
    if (init) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      prod_d   = {(2*WIDTH){1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      prod_d   = product;
      count_d  = count_q + CW'(1);
    end
  end

  // multiplier state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      prod_q   <= {(2*WIDTH){1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/accum_alu_seq.sv
// Sequenced ALU feeding the accumulator: single-cycle logic/arith ops, 8-step MUL,
// registered result/flags with a one-cycle acc_load pulse and a busy handshake.
module accum_alu_seq
  import accum_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH,
  parameter int OPW   = ACC_OPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] acc_q,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_d,
  output logic             acc_load,
  output logic             busy,
  output logic             carry,
  output logic             zero
);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   acc_d_q, acc_d_d;
  logic               load_q, load_d;
  logic               busy_q, busy_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;

  logic [WIDTH:0]     sum_s, diff_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_c_s;
  logic               mul_init_s;
  logic [2*WIDTH-1:0] mul_prod_s;
  logic               mul_last_s;

  shift_add_mul8 #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .init    (mul_init_s),
    .a       (acc_q),
    .b       (operand),
    .product (mul_prod_s),
    .last    (mul_last_s)
  );

  // single-cycle op decoder; SUB borrow is the ninth bit of the widened difference
  always_comb begin
    sum_s  = {1'b0, acc_q} + {1'b0, operand};
    diff_s = {1'b0, acc_q} - {1'b0, operand};
    case (op)
      OP_ADD:  begin alu_res_s = sum_s[WIDTH-1:0];  alu_c_s = sum_s[WIDTH];  end
      OP_SUB:  begin alu_res_s = diff_s[WIDTH-1:0]; alu_c_s = diff_s[WIDTH]; end
      OP_AND:  begin alu_res_s = acc_q & operand;   alu_c_s = 1'b0;          end
      OP_OR:   begin alu_res_s = acc_q | operand;   alu_c_s = 1'b0;          end
      OP_XOR:  begin alu_res_s = acc_q ^ operand;   alu_c_s = 1'b0;          end
      OP_PASS: begin alu_res_s = operand;           alu_c_s = 1'b0;          end
      OP_SHL:  begin alu_res_s = acc_q << 1;        alu_c_s = acc_q[WIDTH-1]; end
      default: begin alu_res_s = {WIDTH{1'b0}};     alu_c_s = 1'b0;          end
    endcase
  end

  // sequencer: only IDLE accepts start, so starts in MUL or DONE are dropped
  always_comb begin
    state_d    = state_q;
    acc_d_d    = acc_d_q;
    carry_d    = carry_q;
    load_d     = 1'b0;
    mul_init_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (op == OP_MUL)) begin
          mul_init_s = 1'b1;
          state_d    = ST_MUL;
        end else if (start) begin
          acc_d_d = alu_res_s;
          carry_d = alu_c_s;
          load_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_last_s) begin
          state_d = ST_DONE;
          acc_d_d = mul_prod_s[WIDTH-1:0];
          carry_d = |mul_prod_s[2*WIDTH-1:WIDTH];
          load_d  = 1'b1;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    zero_d = (acc_d_d == {WIDTH{1'b0}});
    busy_d = (state_d == ST_MUL);
  end

  // registered state, result and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_d_q <= {WIDTH{1'b0}};
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_d_q <= acc_d_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign acc_d    = acc_d_q;
  assign acc_load = load_q;
  assign busy     = busy_q;
  assign carry    = carry_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_accum_alu_seq.sv
// Self-checking bench for accum_alu_seq: directed literal cases plus random traffic
// against a transaction-level model of results and load/busy timing.
module tb_accum_alu_seq;
  import accum_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] acc_q_i = 8'd0;
  logic [7:0] operand = 8'd0;
  logic [7:0] acc_d;
  logic       acc_load, busy, carry, zero;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int c;
    int val;
    bit cy;
  } ld_t;
  ld_t pend[$];
  int  exp_acc = 0;
  bit  exp_c = 1'b0;
  int  free_cyc = 0;
  int  mul_c = -100;

  accum_alu_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .acc_q    (acc_q_i),
    .operand  (operand),
    .acc_d    (acc_d),
    .acc_load (acc_load),
    .busy     (busy),
    .carry    (carry),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void model_eval(input int o, input int a, input int b,
                                     output int r, output bit cy);
    int t;
    cy = 1'b0;
    r  = 0;
    case (o)
      0: begin t = a + b; r = t % 256; cy = (t > 255); end
      1: begin r = (a - b + 256) % 256; cy = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = b;
      6: begin r = (a * 2) % 256; cy = (a >= 128); end
      default: begin t = a * b; r = t % 256; cy = (t > 255); end
    endcase
  endfunction

  // every-cycle comparison against the transaction model
  initial begin
    int  r;
    bit  cy;
    bit  exp_ld;
    bit  exp_busy;
    ld_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend.delete();
        exp_acc  = 0;
        exp_c    = 1'b0;
        free_cyc = 0;
        mul_c    = -100;
        check("rst_acc_d", acc_d, 0);
        check("rst_load", acc_load, 0);
        check("rst_busy", busy, 0);
        check("rst_carry", carry, 0);
        check("rst_zero", zero, 1);
      end else begin
        exp_ld = 1'b0;
        if (pend.size() > 0 && pend[0].c == cyc) begin
          exp_acc = pend[0].val;
          exp_c   = pend[0].cy;
          exp_ld  = 1'b1;
          void'(pend.pop_front());
        end
        exp_busy = (cyc > mul_c) && (cyc <= mul_c + 8);
        check("load", acc_load, exp_ld);
        check("busy", busy, exp_busy);
        check("acc_d", acc_d, exp_acc);
        check("carry", carry, exp_c);
        check("zero", zero, exp_acc == 0);
        if (start && cyc >= free_cyc) begin
          model_eval(op, acc_q_i, operand, r, cy);
          e.val = r;
          e.cy  = cy;
          if (op == OP_MUL) begin
            e.c      = cyc + 9;
            mul_c    = cyc;
            free_cyc = cyc + 10;
          end else begin
            e.c = cyc + 1;
          end
          pend.push_back(e);
        end
      end
    end
  end

  // one transaction with literal expectations; rp>0 re-pulses start that many cycles later
  task automatic do_op(input string nm, input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] b, input int ed, input int ec,
                       input int elat, input int rp);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    start = 1'b1; op = o; acc_q_i = a; operand = b;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      start = (k == rp);
      if (k == rp) begin
        op = OP_ADD; acc_q_i = 8'h11; operand = 8'h22;
      end
      @(negedge clk);
      if (acc_load) begin
        lat = k;
        break;
      end
    end
    check({nm, "_latency"}, lat, elat);
    check({nm, "_acc_d"}, acc_d, ed);
    check({nm, "_carry"}, carry, ec);
    check({nm, "_zero"}, zero, ed == 0);
    @(negedge clk);
    check({nm, "_load_off"}, acc_load, 0);
  endtask

  initial begin
    int loads;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);

    do_op("add_f0_20", OP_ADD, 8'hF0, 8'h20, 8'h10, 1, 1, 0);
    do_op("sub_eq", OP_SUB, 8'h05, 8'h05, 8'h00, 0, 1, 0);
    do_op("sub_borrow", OP_SUB, 8'h03, 8'h05, 8'hFE, 1, 1, 0);
    do_op("mul_0f_11", OP_MUL, 8'h0F, 8'h11, 8'hFF, 0, 9, 0);
    do_op("mul_80_02", OP_MUL, 8'h80, 8'h02, 8'h00, 1, 9, 0);
    do_op("mul_repulse", OP_MUL, 8'h80, 8'h02, 8'h00, 1, 9, 3);

    // back-to-back single-cycle starts
    @(posedge clk); #1;
    start = 1'b1; op = OP_SHL; acc_q_i = 8'h81; operand = 8'h00;
    @(posedge clk); #1;
    op = OP_PASS; acc_q_i = 8'h00; operand = 8'hA5;
    @(negedge clk);
    check("shl_load", acc_load, 1);
    check("shl_acc_d", acc_d, 8'h02);
    check("shl_carry", carry, 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("pass_load", acc_load, 1);
    check("pass_acc_d", acc_d, 8'hA5);
    check("pass_carry", carry, 0);

    // asynchronous reset in the middle of a MUL
    @(posedge clk); #1;
    start = 1'b1; op = OP_MUL; acc_q_i = 8'h0F; operand = 8'h11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_acc_d", acc_d, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    loads = 0;
    repeat (12) begin
      @(negedge clk);
      if (acc_load) loads++;
    end
    check("midrst_no_load", loads, 0);
    do_op("add_after_rst", OP_ADD, 8'h12, 8'h34, 8'h46, 0, 1, 0);

    // random traffic, including starts while busy and in the DONE cycle
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      start   = ($urandom_range(0, 2) == 0);
      op      = 3'($urandom_range(0, 7));
      acc_q_i = 8'($urandom_range(0, 255));
      operand = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) operand = 8'h00;
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
